// File: rtl/issue_pkg.sv
// Shared types and helpers for the issue-queue age arbiter.
// Helpers operate on a 32-bit mask so any slot count up to the maximum can use them.
package issue_pkg;

    localparam int NUM_SLOTS_DEFAULT = 8;
    localparam int MAX_SLOTS         = 32;

    typedef logic [$clog2(NUM_SLOTS_DEFAULT)-1:0] slot_idx_t;
    typedef logic [NUM_SLOTS_DEFAULT-1:0]         slot_mask_t;
    typedef logic [MAX_SLOTS-1:0]                 wide_mask_t;
    typedef logic [$clog2(MAX_SLOTS)-1:0]         wide_idx_t;

    function automatic wide_idx_t onehot_to_idx(input wide_mask_t oh);
        wide_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (oh[i]) begin
                idx = idx | wide_idx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic wide_mask_t lowest_set_onehot(input wide_mask_t v);
        return v & (~v + wide_mask_t'(1));
    endfunction

endpackage

// File: rtl/issue_age_matrix.sv
// Age matrix: older_q[i][j] set means slot i was allocated before slot j.
// Produces a one-hot select of the oldest eligible slot.
module issue_age_matrix
    import issue_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [NUM_SLOTS-1:0] alloc_oh,
    input  logic [NUM_SLOTS-1:0] dealloc_oh,
    input  logic [NUM_SLOTS-1:0] busy,
    input  logic [NUM_SLOTS-1:0] eligible,
    output logic [NUM_SLOTS-1:0] select
);

    logic [NUM_SLOTS-1:0] older_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] older_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] cand;

    // A new entry is younger than everything busy; a freed entry loses all age relations.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                older_d[i][j] = older_q[i][j];
                if (alloc_oh[i]) begin
                    older_d[i][j] = 1'b0;
                end
                if (alloc_oh[j] && (i != j)) begin
                    older_d[i][j] = busy[i];
                end
                if (dealloc_oh[i] || dealloc_oh[j]) begin
                    older_d[i][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (reset || clear) begin
                older_q[i] <= '0;
            end else begin
                older_q[i] <= older_d[i];
            end
        end
    end

    // Busy entries are totally ordered, so the lowest-index pick only matters for unreachable ties.
    always_comb begin
        cand = eligible;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (eligible[j] && older_q[j][i]) begin
                    cand[i] = 1'b0;
                end
            end
        end
        select = cand & (~cand + NUM_SLOTS'(1));
    end

endmodule

// File: rtl/issue_age_arbiter.sv
// Issue-queue controller: allocates the lowest free slot to dispatch and
// grants the oldest requesting slot to the single functional-unit port.
module issue_age_arbiter
    import issue_pkg::*;
#(
    parameter  int NUM_SLOTS  = NUM_SLOTS_DEFAULT,
    localparam int SLOT_IDX_W = $clog2(NUM_SLOTS),
    localparam int FC_W       = $clog2(NUM_SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dis_valid,
    output logic                  dis_ready,
    output logic [SLOT_IDX_W-1:0] dis_slot,
    output logic [NUM_SLOTS-1:0]  slot_write,
    input  logic [NUM_SLOTS-1:0]  slot_request,
    input  logic                  fu_ready,
    output logic [NUM_SLOTS-1:0]  slot_grant,
    output logic                  issue_valid,
    output logic [SLOT_IDX_W-1:0] issue_slot,
    input  logic                  flush,
    output logic [FC_W-1:0]       free_count
);

    logic [NUM_SLOTS-1:0] busy_q, busy_d;
    logic [FC_W-1:0]      free_count_q, free_count_d;
    logic [NUM_SLOTS-1:0] free_oh;
    logic [NUM_SLOTS-1:0] eligible;
    wide_mask_t           free_wide;
    wide_mask_t           grant_wide;

    // Allocation looks only at registered busy, so a slot freed this cycle waits a cycle.
    always_comb begin
        free_wide                  = '0;
        free_wide[NUM_SLOTS-1:0]   = ~busy_q;
        free_oh                    = NUM_SLOTS'(lowest_set_onehot(free_wide));
        dis_slot                   = SLOT_IDX_W'(onehot_to_idx(free_wide & lowest_set_onehot(free_wide)));
        dis_ready                  = (|(~busy_q)) && !flush && !reset;
        slot_write                 = (dis_valid && dis_ready) ? free_oh : '0;
    end

    assign eligible = slot_request & busy_q & {NUM_SLOTS{fu_ready && !flush && !reset}};

    issue_age_matrix #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_age (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .alloc_oh   (slot_write),
        .dealloc_oh (slot_grant),
        .busy       (busy_q),
        .eligible   (eligible),
        .select     (slot_grant)
    );

    always_comb begin
        grant_wide                = '0;
        grant_wide[NUM_SLOTS-1:0] = slot_grant;
        issue_valid               = |slot_grant;
        issue_slot                = SLOT_IDX_W'(onehot_to_idx(grant_wide));
    end

    // Grant and allocation in the same cycle cancel out in the free count.
    always_comb begin
        busy_d       = (busy_q & ~slot_grant) | slot_write;
        free_count_d = free_count_q;
        case ({|slot_write, |slot_grant})
            2'b10:   free_count_d = free_count_q - FC_W'(1);
            2'b01:   free_count_d = free_count_q + FC_W'(1);
            default: free_count_d = free_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            busy_q       <= '0;
            free_count_q <= FC_W'(NUM_SLOTS);
        end else begin
            busy_q       <= busy_d;
            free_count_q <= free_count_d;
        end
    end

    assign free_count = free_count_q;

endmodule

// File: tb/tb_issue_age_arbiter.sv
// Bench for issue_age_arbiter: directed vector table, a flush sequence,
// then random traffic against an allocation-order queue model.
module tb_issue_age_arbiter;
    import issue_pkg::*;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       dis_valid;
    logic       dis_ready;
    logic [2:0] dis_slot;
    logic [7:0] slot_write;
    logic [7:0] slot_request;
    logic       fu_ready;
    logic [7:0] slot_grant;
    logic       issue_valid;
    logic [2:0] issue_slot;
    logic       flush;
    logic [3:0] free_count;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       rst;
        logic       dv;
        logic [7:0] req;
        logic       fr;
        logic       fl;
        logic       expReady;
        logic [2:0] expSlot;
        logic [7:0] expWrite;
        logic [7:0] expGrant;
        logic [3:0] expFc;
    } vec_t;

    vec_t vecs[$];

    // Reference model: slots listed in allocation order, oldest first.
    int         ageq[$];
    slot_mask_t mbusy;

    logic       mR;
    logic [2:0] mS;
    logic [7:0] mW;
    logic [7:0] mG;
    logic [3:0] mFc;

    issue_age_arbiter #(.NUM_SLOTS(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .dis_valid    (dis_valid),
        .dis_ready    (dis_ready),
        .dis_slot     (dis_slot),
        .slot_write   (slot_write),
        .slot_request (slot_request),
        .fu_ready     (fu_ready),
        .slot_grant   (slot_grant),
        .issue_valid  (issue_valid),
        .issue_slot   (issue_slot),
        .flush        (flush),
        .free_count   (free_count)
    );

    always #5 clk = ~clk;

    task addVec(input logic rst, input logic dv, input logic [7:0] req, input logic fr,
                input logic fl, input logic eR, input logic [2:0] eS, input logic [7:0] eW,
                input logic [7:0] eG, input logic [3:0] eFc);
        vec_t v;
        v.rst = rst; v.dv = dv; v.req = req; v.fr = fr; v.fl = fl;
        v.expReady = eR; v.expSlot = eS; v.expWrite = eW; v.expGrant = eG; v.expFc = eFc;
        vecs.push_back(v);
    endtask

    function automatic logic [2:0] idxOf(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

    task modelExpect();
        bit found;
        mR = (ageq.size() < N) && !flush && !reset;
        mS = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!mbusy[i]) mS = 3'(i);
        end
        mW = (dis_valid && mR) ? (8'd1 << mS) : 8'd0;
        mG = 8'd0;
        found = 1'b0;
        if (fu_ready && !flush && !reset) begin
            foreach (ageq[k]) begin
                if (!found && slot_request[ageq[k]]) begin
                    mG = 8'd1 << ageq[k];
                    found = 1'b1;
                end
            end
        end
        mFc = 4'(N - ageq.size());
    endtask

    task modelUpdate();
        if (reset || flush) begin
            ageq.delete();
            mbusy = '0;
        end else begin
            if (mG != 8'd0) begin
                for (int k = ageq.size() - 1; k >= 0; k--) begin
                    if (ageq[k] == int'(idxOf(mG))) ageq.delete(k);
                end
                mbusy[idxOf(mG)] = 1'b0;
            end
            if (mW != 8'd0) begin
                ageq.push_back(int'(idxOf(mW)));
                mbusy[idxOf(mW)] = 1'b1;
            end
        end
    endtask

    task applyStimulus(input logic rst, input logic dv, input logic [7:0] req,
                       input logic fr, input logic fl);
        reset        = rst;
        dis_valid    = dv;
        slot_request = req;
        fu_ready     = fr;
        flush        = fl;
        @(negedge clk);
        modelExpect();
    endtask

    task finishCycle();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task checkOutput(input string tag, input logic eR, input logic [2:0] eS,
                     input logic [7:0] eW, input logic [7:0] eG, input logic [3:0] eFc);
        int freeBits;
        vectors++;
        if (dis_ready !== eR) begin
            miscompares++;
            $display("[TB] FAIL %s dis_ready: got %b want %b", tag, dis_ready, eR);
        end
        if (dis_slot !== eS) begin
            miscompares++;
            $display("[TB] FAIL %s dis_slot: got %0d want %0d", tag, dis_slot, eS);
        end
        if (slot_write !== eW) begin
            miscompares++;
            $display("[TB] FAIL %s slot_write: got %h want %h", tag, slot_write, eW);
        end
        if (slot_grant !== eG) begin
            miscompares++;
            $display("[TB] FAIL %s slot_grant: got %h want %h", tag, slot_grant, eG);
        end
        if (issue_valid !== (eG != 8'd0)) begin
            miscompares++;
            $display("[TB] FAIL %s issue_valid: got %b want %b", tag, issue_valid, eG != 8'd0);
        end
        if (issue_slot !== idxOf(eG)) begin
            miscompares++;
            $display("[TB] FAIL %s issue_slot: got %0d want %0d", tag, issue_slot, idxOf(eG));
        end
        if (free_count !== eFc) begin
            miscompares++;
            $display("[TB] FAIL %s free_count: got %0d want %0d", tag, free_count, eFc);
        end
        freeBits = 0;
        for (int i = 0; i < N; i++) begin
            if (!dut.busy_q[i]) freeBits++;
        end
        if (int'(free_count) != freeBits) begin
            miscompares++;
            $display("[TB] FAIL %s invariant free_count: got %0d want popcount %0d", tag, free_count, freeBits);
        end
        if (!$onehot0(slot_grant)) begin
            miscompares++;
            $display("[TB] FAIL %s grant onehot: got %h want at most one bit", tag, slot_grant);
        end
    endtask

    initial begin
        string tag;
        logic rst, dv, fr, fl;
        logic [7:0] req;

        // rst dv req fr fl | ready slot write grant free
        addVec(1, 1, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 8);
        addVec(0, 1, 8'h00, 0, 0, 1, 0, 8'h01, 8'h00, 8);
        addVec(0, 1, 8'h00, 0, 0, 1, 1, 8'h02, 8'h00, 7);
        addVec(0, 1, 8'h00, 0, 0, 1, 2, 8'h04, 8'h00, 6);
        addVec(0, 0, 8'h06, 1, 0, 1, 3, 8'h00, 8'h02, 5);
        addVec(0, 0, 8'h04, 1, 0, 1, 1, 8'h00, 8'h04, 6);
        addVec(0, 1, 8'h00, 0, 0, 1, 1, 8'h02, 8'h00, 7);
        addVec(0, 1, 8'h00, 0, 0, 1, 2, 8'h04, 8'h00, 6);
        addVec(0, 1, 8'h00, 0, 0, 1, 3, 8'h08, 8'h00, 5);
        addVec(0, 1, 8'h00, 0, 0, 1, 4, 8'h10, 8'h00, 4);
        addVec(0, 1, 8'h00, 0, 0, 1, 5, 8'h20, 8'h00, 3);
        addVec(0, 1, 8'h00, 0, 0, 1, 6, 8'h40, 8'h00, 2);
        addVec(0, 1, 8'h00, 0, 0, 1, 7, 8'h80, 8'h00, 1);
        addVec(0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        addVec(0, 1, 8'h01, 1, 0, 0, 0, 8'h00, 8'h01, 0);
        addVec(0, 1, 8'h00, 0, 0, 1, 0, 8'h01, 8'h00, 1);
        addVec(0, 0, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        addVec(0, 0, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h02, 0);
        addVec(0, 1, 8'h08, 1, 0, 1, 1, 8'h02, 8'h08, 1);
        addVec(0, 0, 8'h03, 1, 0, 1, 3, 8'h00, 8'h01, 1);
        addVec(0, 0, 8'h04, 1, 0, 1, 0, 8'h00, 8'h04, 2);
        addVec(0, 1, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00, 3);
        addVec(0, 0, 8'hFF, 1, 0, 1, 0, 8'h00, 8'h00, 8);
        addVec(0, 1, 8'hFF, 1, 0, 1, 0, 8'h01, 8'h00, 8);
        addVec(0, 0, 8'hFF, 1, 0, 1, 1, 8'h00, 8'h01, 7);
        addVec(1, 1, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 8);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 8);

        reset = 1'b1; dis_valid = 1'b0; slot_request = '0; fu_ready = 1'b0; flush = 1'b0;
        ageq.delete();
        mbusy = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        $display("[TB] directed vector table");
        foreach (vecs[v]) begin
            applyStimulus(vecs[v].rst, vecs[v].dv, vecs[v].req, vecs[v].fr, vecs[v].fl);
            tag = $sformatf("table[%0d]", v);
            checkOutput(tag, vecs[v].expReady, vecs[v].expSlot, vecs[v].expWrite,
                        vecs[v].expGrant, vecs[v].expFc);
            finishCycle();
        end

        $display("[TB] flush with busy slots clears age matrix");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 8'h00, 0, 0);
            checkOutput("flushFill", 1'b1, 3'(k), 8'd1 << k, 8'h00, 4'(N - k));
            finishCycle();
        end
        applyStimulus(0, 1, 8'h07, 1, 1);
        checkOutput("flushCycle", 1'b0, 3'd3, 8'h00, 8'h00, 4'd5);
        finishCycle();
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("afterFlush", 1'b1, 3'd0, 8'h00, 8'h00, 4'd8);
        vectors++;
        if (dut.busy_q !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL afterFlush busy: got %h want 00", dut.busy_q);
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (dut.u_age.older_q[i] !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL afterFlush older row %0d: got %h want 00", i, dut.u_age.older_q[i]);
            end
        end
        finishCycle();

        $display("[TB] random traffic against queue model");
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            dv  = ($urandom_range(0, 3) != 0);
            fr  = ($urandom_range(0, 3) != 0);
            req = 8'($urandom) & 8'($urandom);
            applyStimulus(rst, dv, req, fr, fl);
            tag = $sformatf("rand[%0d]", c);
            checkOutput(tag, mR, mS, mW, mG, mFc);
            finishCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
